// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces three active-low pushbuttons.
// Each accepted press becomes a one-cycle pulse; masked keys auto-repeat while held.
module key_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_PERIOD   = 5000000,
    parameter logic [2:0] REPEAT_MASK     = 3'b011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] key_n,
    output logic [2:0] keys,
    output logic [2:0] key_held
);
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAXP   = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] DEB_T = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_T  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_T  = CW'(REPEAT_PERIOD - 1);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DEB_PRESS   = 3'd1;
    localparam logic [2:0] HOLD        = 3'd2;
    localparam logic [2:0] REPEAT      = 3'd3;
    localparam logic [2:0] DEB_RELEASE = 3'd4;

    logic [2:0]    sync1_q, sync2_q, s;
    logic [2:0]    state_q [3];
    logic [2:0]    state_d [3];
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    keys_q, keys_d, held_q, held_d;

    assign s        = ~sync2_q;
    assign keys     = keys_q;
    assign key_held = held_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i] + 1'b1;
            keys_d[i]  = 1'b0;
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (s[i]) state_d[i] = DEB_PRESS;
                end
                DEB_PRESS:
                    if (!s[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_T) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = '0;
                        keys_d[i]  = 1'b1;
                    end
                HOLD:
                    if (!s[i]) begin
                        state_d[i] = DEB_RELEASE;
                        cnt_d[i]   = '0;
                    end else if (!REPEAT_MASK[i]) begin
                        cnt_d[i] = cnt_q[i];
                    end else if (cnt_q[i] == RD_T) begin
                        state_d[i] = REPEAT;
                        cnt_d[i]   = '0;
                        keys_d[i]  = 1'b1;
                    end
                REPEAT:
                    if (!s[i]) begin
                        state_d[i] = DEB_RELEASE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == RP_T) begin
                        cnt_d[i]  = '0;
                        keys_d[i] = 1'b1;
                    end
                DEB_RELEASE:
                    // a bounce back to pressed restarts repeat timing without a pulse
                    if (s[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_T) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] == HOLD) || (state_d[i] == REPEAT) || (state_d[i] == DEB_RELEASE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            keys_q  <= 3'b000;
            held_q  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            keys_q  <= keys_d;
            held_q  <= held_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random key activity, checked every cycle
// against a run-length model of debounce, hold and repeat timing.
module tb_key_conditioner;
    localparam int         D    = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam logic [2:0] MASK = 3'b011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic [2:0] keys, key_held;

    int checks = 0;
    int fails  = 0;

    logic [2:0] m_s1, m_s2, exp_keys, exp_held;
    int         m_run [3];
    int         m_age [3];
    int         pcount [3];

    key_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .keys(keys), .key_held(key_held)
    );

    always #5 clk = ~clk;

    task automatic mreset();
        m_s1     = 3'b111;
        m_s2     = 3'b111;
        exp_keys = 3'b000;
        exp_held = 3'b000;
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0;
            m_age[k] = 0;
        end
    endtask

    task automatic check(input string tag);
        checks++;
        assert (keys === exp_keys) else begin
            fails++;
            $error("FAIL %s keys: got %b expected %b at %0t", tag, keys, exp_keys, $time);
        end
        checks++;
        assert (key_held === exp_held) else begin
            fails++;
            $error("FAIL %s key_held: got %b expected %b at %0t", tag, key_held, exp_held, $time);
        end
    endtask

    // one clock edge: advance the model on the inputs seen at the edge, then check
    task automatic tick(input string tag);
        logic s;
        @(posedge clk);
        if (reset) mreset();
        else begin
            for (int k = 0; k < 3; k++) begin
                s = ~m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = key_n[k];
                exp_keys[k] = 1'b0;
                if (!exp_held[k]) begin
                    m_run[k] = s ? m_run[k] + 1 : 0;
                    if (m_run[k] == D + 1) begin
                        exp_keys[k] = 1'b1;
                        exp_held[k] = 1'b1;
                        m_run[k] = 0;
                        m_age[k] = 0;
                    end
                end else if (!s) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        exp_held[k] = 1'b0;
                        m_run[k] = 0;
                    end
                end else if (m_run[k] != 0) begin
                    m_run[k] = 0;
                    m_age[k] = 0;
                end else begin
                    m_age[k]++;
                    if (MASK[k] && (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0)))
                        exp_keys[k] = 1'b1;
                end
            end
        end
        #1;
        check(tag);
        for (int k = 0; k < 3; k++) if (keys[k]) pcount[k]++;
    endtask

    task automatic drive(input logic [2:0] kn, input int n, input string tag);
        key_n = kn;
        repeat (n) tick(tag);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) pcount[k] = 0;
    endtask

    initial begin
        int rem [3];
        mreset();
        clear_counts();
        repeat (3) tick("reset");
        reset = 1'b0;
        drive(3'b111, 5, "idle");

        clear_counts();
        drive(3'b101, 8, "clean_press");
        drive(3'b111, 12, "clean_release");
        checks++;
        assert (pcount[1] === 1) else begin
            fails++;
            $error("FAIL clean_count: got %0d expected 1", pcount[1]);
        end

        clear_counts();
        for (int r = 0; r < 5; r++) begin
            drive(3'b110, 3, "glitch_low");
            drive(3'b111, 1, "glitch_high");
        end
        drive(3'b111, 10, "glitch_tail");
        checks++;
        assert (pcount[0] === 0) else begin
            fails++;
            $error("FAIL glitch_count: got %0d expected 0", pcount[0]);
        end

        drive(3'b101, 40, "repeat_hold");
        drive(3'b111, 12, "repeat_release");

        clear_counts();
        drive(3'b011, 40, "clear_hold");
        drive(3'b111, 12, "clear_release");
        checks++;
        assert (pcount[2] === 1) else begin
            fails++;
            $error("FAIL clear_count: got %0d expected 1", pcount[2]);
        end

        drive(3'b100, 9, "simul_press");
        drive(3'b110, 3, "simul_rel1");
        drive(3'b100, 2, "simul_bounce");
        drive(3'b111, 12, "simul_release");

        drive(3'b101, 10, "pre_reset_hold");
        #3 reset = 1'b1;
        mreset();
        #1 check("async_reset");
        repeat (3) tick("in_reset");
        #3 reset = 1'b0;
        clear_counts();
        drive(3'b101, 12, "post_reset_hold");
        checks++;
        assert (pcount[1] === 1) else begin
            fails++;
            $error("FAIL post_reset_count: got %0d expected 1", pcount[1]);
        end
        drive(3'b111, 12, "post_reset_release");

        for (int k = 0; k < 3; k++) rem[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    rem[k] = $urandom_range(1, 30);
                end
                rem[k]--;
            end
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
